// File: rtl/riscv_core_lsu_amo.sv
// Load/store/atomic initiator for the core data memory port.
// Sequences loads, stores, RV64A AMOs and LR/SC, and holds the LR reservation.
module riscv_core_lsu_amo #(
    parameter int XLEN = 64,
    parameter int MLEN = 256
) (
    input  logic            i_data_mem_clk,
    input  logic            i_data_mem_rst_n,
    input  logic            i_lsu_valid,
    output logic            o_lsu_ready,
    input  logic [1:0]      i_lsu_op,
    input  logic [4:0]      i_lsu_funct5,
    input  logic [1:0]      i_lsu_size,
    input  logic            i_lsu_unsigned,
    input  logic [XLEN-1:0] i_lsu_base,
    input  logic [XLEN-1:0] i_lsu_offset,
    input  logic [XLEN-1:0] i_lsu_wdata,
    output logic            o_lsu_done,
    output logic [XLEN-1:0] o_lsu_rdata,
    output logic            o_lsu_fault,
    output logic            o_mem_w_en,
    output logic            o_mem_ld_extend,
    output logic [1:0]      o_mem_r_w_size,
    output logic [XLEN-1:0] o_mem_address,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic [XLEN-1:0] i_mem_rdata
);
    localparam logic [1:0] OP_LD = 2'b00, OP_ST = 2'b01, OP_AMO = 2'b10;
    localparam logic [4:0] F_ADD = 5'b00000, F_SWAP = 5'b00001, F_LR = 5'b00010,
                           F_SC = 5'b00011, F_XOR = 5'b00100, F_OR = 5'b01000,
                           F_AND = 5'b01100, F_MIN = 5'b10000, F_MAX = 5'b10100,
                           F_MINU = 5'b11000, F_MAXU = 5'b11100;

    typedef enum logic [2:0] {IDLE, ACCESS, AMO_RD, AMO_WR, RESP} state_e;
    state_e state_q, state_d;

    logic [1:0]      op_q;
    logic [4:0]      f5_q;
    logic [1:0]      size_q;
    logic            uns_q, fault_q, sc_ok_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
    logic            res_vld_q;
    logic [XLEN-4:0] res_addr_q;

    // Request decode and fault check at acceptance.
    logic            accept, is_amo_in, f5_legal, misalign, oor, fault_in;
    logic [XLEN-1:0] addr;
    logic [3:0]      nbytes;

    assign accept    = i_lsu_valid & o_lsu_ready;
    assign addr      = i_lsu_base + i_lsu_offset;
    assign nbytes    = 4'd1 << i_lsu_size;
    assign is_amo_in = (i_lsu_op == OP_AMO);

    always_comb begin
        f5_legal = 1'b0;
        case (i_lsu_funct5)
            F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
            F_MIN, F_MAX, F_MINU, F_MAXU: f5_legal = 1'b1;
            default: f5_legal = 1'b0;
        endcase
        misalign = 1'b0;
        case (i_lsu_size)
            2'b01:   misalign = addr[0];
            2'b10:   misalign = |addr[1:0];
            2'b11:   misalign = |addr[2:0];
            default: misalign = 1'b0;
        endcase
    end

    // Written as a subtraction so a huge addr cannot wrap past the check.
    assign oor      = addr > (XLEN'(MLEN) - XLEN'(nbytes));
    assign fault_in = misalign | oor | (i_lsu_op == 2'b11)
                    | (is_amo_in & ~i_lsu_size[1]) | (is_amo_in & ~f5_legal);

    logic is_lr_q, is_sc_q, res_hit_q;
    assign is_lr_q   = (op_q == OP_AMO) && (f5_q == F_LR);
    assign is_sc_q   = (op_q == OP_AMO) && (f5_q == F_SC);
    assign res_hit_q = (addr_q[XLEN-1:3] == res_addr_q);

    // AMO datapath; rdata_q holds the old value from AMO_RD onward.
    logic            is_w;
    logic [XLEN-1:0] a_s, a_u, b_s, b_u, amo_r, amo_wdata;
    logic            lt_s, lt_u;

    always_comb begin
        is_w = (size_q == 2'b10);
        a_s  = is_w ? {{(XLEN-32){rdata_q[31]}}, rdata_q[31:0]} : rdata_q;
        a_u  = is_w ? {{(XLEN-32){1'b0}}, rdata_q[31:0]} : rdata_q;
        b_s  = is_w ? {{(XLEN-32){wdata_q[31]}}, wdata_q[31:0]} : wdata_q;
        b_u  = is_w ? {{(XLEN-32){1'b0}}, wdata_q[31:0]} : wdata_q;
        lt_s = $signed(a_s) < $signed(b_s);
        lt_u = a_u < b_u;
        case (f5_q)
            F_ADD:   amo_r = a_s + b_s;
            F_XOR:   amo_r = a_s ^ b_s;
            F_OR:    amo_r = a_s | b_s;
            F_AND:   amo_r = a_s & b_s;
            F_MIN:   amo_r = lt_s ? a_s : b_s;
            F_MAX:   amo_r = lt_s ? b_s : a_s;
            F_MINU:  amo_r = lt_u ? a_u : b_u;
            F_MAXU:  amo_r = lt_u ? b_u : a_u;
            default: amo_r = b_s;
        endcase
        amo_wdata = is_w ? {{(XLEN-32){amo_r[31]}}, amo_r[31:0]} : amo_r;
    end

    always_ff @(posedge i_data_mem_clk or negedge i_data_mem_rst_n) begin
        if (!i_data_mem_rst_n) state_q <= IDLE;
        else                   state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) begin
                if (fault_in)                                    state_d = RESP;
                else if (is_amo_in && i_lsu_funct5 != F_LR &&
                         i_lsu_funct5 != F_SC)                   state_d = AMO_RD;
                else                                             state_d = ACCESS;
            end
            ACCESS:  state_d = RESP;
            AMO_RD:  state_d = AMO_WR;
            AMO_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_lsu_ready     = (state_q == IDLE);
        o_lsu_done      = (state_q == RESP);
        o_lsu_fault     = (state_q == RESP) & fault_q;
        o_lsu_rdata     = rdata_q;
        o_mem_w_en      = 1'b0;
        o_mem_ld_extend = 1'b0;
        o_mem_r_w_size  = 2'b00;
        o_mem_address   = '0;
        o_mem_wdata     = '0;
        case (state_q)
            ACCESS: begin
                o_mem_r_w_size  = size_q;
                o_mem_address   = addr_q;
                o_mem_wdata     = wdata_q;
                o_mem_w_en      = (op_q == OP_ST) | (is_sc_q & sc_ok_q);
                o_mem_ld_extend = (op_q == OP_LD) ? ~uns_q : is_lr_q;
            end
            AMO_RD: begin
                o_mem_r_w_size  = size_q;
                o_mem_address   = addr_q;
                o_mem_ld_extend = 1'b1;
            end
            AMO_WR: begin
                o_mem_r_w_size  = size_q;
                o_mem_address   = addr_q;
                o_mem_wdata     = amo_wdata;
                o_mem_w_en      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_data_mem_clk or negedge i_data_mem_rst_n) begin
        if (!i_data_mem_rst_n) begin
            op_q       <= '0;
            f5_q       <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            fault_q    <= 1'b0;
            sc_ok_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            res_vld_q  <= 1'b0;
            res_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q    <= i_lsu_op;
                    f5_q    <= i_lsu_funct5;
                    size_q  <= i_lsu_size;
                    uns_q   <= i_lsu_unsigned;
                    addr_q  <= addr;
                    wdata_q <= i_lsu_wdata;
                    fault_q <= fault_in;
                    rdata_q <= '0;
                    sc_ok_q <= res_vld_q && (addr[XLEN-1:3] == res_addr_q);
                    if (is_amo_in && i_lsu_funct5 == F_SC)
                        res_vld_q <= 1'b0;
                    else if (is_amo_in && i_lsu_funct5 == F_LR && !fault_in) begin
                        res_vld_q  <= 1'b1;
                        res_addr_q <= addr[XLEN-1:3];
                    end
                end
                ACCESS: begin
                    if (op_q == OP_LD || is_lr_q) rdata_q <= i_mem_rdata;
                    if (is_sc_q)                  rdata_q <= {{(XLEN-1){1'b0}}, ~sc_ok_q};
                    if (op_q == OP_ST && res_hit_q) res_vld_q <= 1'b0;
                end
                AMO_RD: rdata_q <= i_mem_rdata;
                AMO_WR: if (res_hit_q) res_vld_q <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_core_lsu_amo.sv
// Directed bench for riscv_core_lsu_amo with a byte-array memory model
// (synchronous write, combinational sized read with optional sign extension).
module tb_riscv_core_lsu_amo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ready, uns, done, fault;
    logic [1:0]  op, size;
    logic [4:0]  f5;
    logic [63:0] base, offset, wdata, rdata;
    logic        m_wen, m_ext;
    logic [1:0]  m_size;
    logic [63:0] m_addr, m_wdata, m_rdata;

    always #5 clk = ~clk;

    riscv_core_lsu_amo #(.XLEN(64), .MLEN(256)) dut (
        .i_data_mem_clk(clk), .i_data_mem_rst_n(rst_n),
        .i_lsu_valid(valid), .o_lsu_ready(ready), .i_lsu_op(op),
        .i_lsu_funct5(f5), .i_lsu_size(size), .i_lsu_unsigned(uns),
        .i_lsu_base(base), .i_lsu_offset(offset), .i_lsu_wdata(wdata),
        .o_lsu_done(done), .o_lsu_rdata(rdata), .o_lsu_fault(fault),
        .o_mem_w_en(m_wen), .o_mem_ld_extend(m_ext), .o_mem_r_w_size(m_size),
        .o_mem_address(m_addr), .o_mem_wdata(m_wdata), .i_mem_rdata(m_rdata)
    );

    logic [7:0] mem [256];
    int wen_cnt = 0, done_cnt = 0;

    always @(posedge clk) begin
        if (m_wen) begin
            wen_cnt++;
            for (int k = 0; k < 8; k++)
                if (k < (1 << m_size)) mem[(m_addr[7:0] + k) & 8'hFF] <= m_wdata[k*8 +: 8];
        end
        if (done) done_cnt++;
    end

    always_comb begin
        logic [63:0] raw;
        raw = '0;
        for (int k = 0; k < 8; k++)
            if (k < (1 << m_size)) raw[k*8 +: 8] = mem[(m_addr[7:0] + k) & 8'hFF];
        m_rdata = raw;
        if (m_ext)
            case (m_size)
                2'b00: m_rdata = {{56{raw[7]}}, raw[7:0]};
                2'b01: m_rdata = {{48{raw[15]}}, raw[15:0]};
                2'b10: m_rdata = {{32{raw[31]}}, raw[31:0]};
                default: m_rdata = raw;
            endcase
    end

    function automatic logic [63:0] peek8(input int a);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = mem[a + k];
        return v;
    endfunction

    int n_cmp = 0, n_err = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [63:0] r_rdata;
    logic        r_fault;
    int          r_lat, r_wen;

    localparam logic [1:0] LD = 2'b00, ST = 2'b01, AMO = 2'b10;
    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, D = 2'b11;

    // Issue one request, wait for done (bounded), then return to IDLE.
    task automatic req(input logic [1:0] o, input logic [4:0] fn, input logic [1:0] sz,
                       input logic u, input logic [63:0] b, input logic [63:0] off,
                       input logic [63:0] wd);
        int w0;
        w0 = wen_cnt;
        op = o; f5 = fn; size = sz; uns = u; base = b; offset = off; wdata = wd;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        r_lat = 1;
        while (!done && r_lat < 20) begin
            @(posedge clk); #1;
            r_lat++;
        end
        if (!done) chk("done_timeout", 64'(done), 64'd1);
        r_rdata = rdata;
        r_fault = fault;
        @(posedge clk); #1;
        r_wen = wen_cnt - w0;
    endtask

    initial begin
        int w0, d0;
        rst_n = 1'b0; valid = 1'b0; op = '0; f5 = '0; size = '0; uns = 1'b0;
        base = '0; offset = '0; wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_wen", 64'(m_wen), 64'd0);
        chk("rst_addr", m_addr, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        req(ST, 5'd0, D, 1'b0, 64'h8, 64'h8, 64'h8000_0000_0000_00FF);
        chk("st_lat", 64'(r_lat), 64'd2);
        chk("st_mem", peek8(16), 64'h8000_0000_0000_00FF);
        chk("st_rdata", r_rdata, 64'd0);
        req(LD, 5'd0, B, 1'b0, 64'h10, 64'h0, 64'h0);
        chk("lb_rdata", r_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("lb_lat", 64'(r_lat), 64'd2);
        req(LD, 5'd0, B, 1'b1, 64'h10, 64'h0, 64'h0);
        chk("lbu_rdata", r_rdata, 64'hFF);

        req(LD, 5'd0, W, 1'b0, 64'h12, 64'h0, 64'h0);
        chk("misal_fault", 64'(r_fault), 64'd1);
        chk("misal_rdata", r_rdata, 64'd0);
        chk("misal_wen", 64'(r_wen), 64'd0);
        chk("misal_lat", 64'(r_lat), 64'd1);
        req(ST, 5'd0, D, 1'b0, 64'hF8, 64'h8, 64'h1);
        chk("oor_fault", 64'(r_fault), 64'd1);
        chk("oor_wen", 64'(r_wen), 64'd0);
        req(ST, 5'd0, D, 1'b0, 64'hF0, 64'h8, 64'hDEAD_BEEF_CAFE_F00D);
        chk("top_fault", 64'(r_fault), 64'd0);
        chk("top_mem", peek8(248), 64'hDEAD_BEEF_CAFE_F00D);
        req(2'b11, 5'd0, D, 1'b0, 64'h0, 64'h0, 64'h0);
        chk("op11_fault", 64'(r_fault), 64'd1);
        req(AMO, 5'b00000, H, 1'b0, 64'h20, 64'h0, 64'h1);
        chk("amoh_fault", 64'(r_fault), 64'd1);
        chk("amoh_wen", 64'(r_wen), 64'd0);
        req(AMO, 5'b00101, D, 1'b0, 64'h40, 64'h0, 64'h1);
        chk("badf5_fault", 64'(r_fault), 64'd1);

        req(ST, 5'd0, D, 1'b0, 64'h20, 64'h0, 64'h1122_3344_7FFF_FFFF);
        req(AMO, 5'b00000, W, 1'b0, 64'h20, 64'h0, 64'h1);
        chk("amoadd_rdata", r_rdata, 64'h0000_0000_7FFF_FFFF);
        chk("amoadd_mem", peek8(32), 64'h1122_3344_8000_0000);
        chk("amoadd_lat", 64'(r_lat), 64'd3);
        chk("amoadd_fault", 64'(r_fault), 64'd0);
        req(LD, 5'd0, W, 1'b0, 64'h20, 64'h0, 64'h0);
        chk("lw_after", r_rdata, 64'hFFFF_FFFF_8000_0000);
        req(AMO, 5'b11000, W, 1'b0, 64'h20, 64'h0, 64'h5);
        chk("minuw_rdata", r_rdata, 64'hFFFF_FFFF_8000_0000);
        chk("minuw_mem", peek8(32), 64'h1122_3344_0000_0005);
        req(AMO, 5'b10000, W, 1'b0, 64'h20, 64'h0, 64'h0000_0000_FFFF_FFFF);
        chk("minw_rdata", r_rdata, 64'h5);
        chk("minw_mem", peek8(32), 64'h1122_3344_FFFF_FFFF);

        req(ST, 5'd0, D, 1'b0, 64'h40, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE);
        req(AMO, 5'b10100, D, 1'b0, 64'h40, 64'h0, 64'h5);
        chk("amomax_rdata", r_rdata, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("amomax_mem", peek8(64), 64'h5);
        req(ST, 5'd0, D, 1'b0, 64'h40, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE);
        req(AMO, 5'b11100, D, 1'b0, 64'h40, 64'h0, 64'h5);
        chk("amomaxu_rdata", r_rdata, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("amomaxu_mem", peek8(64), 64'hFFFF_FFFF_FFFF_FFFE);

        req(ST, 5'd0, D, 1'b0, 64'h80, 64'h0, 64'h1234);
        req(AMO, 5'b00010, D, 1'b0, 64'h80, 64'h0, 64'h0);
        chk("lr_rdata", r_rdata, 64'h1234);
        req(AMO, 5'b00011, D, 1'b0, 64'h80, 64'h0, 64'hAB);
        chk("sc1_rdata", r_rdata, 64'd0);
        chk("sc1_mem", peek8(128), 64'hAB);
        chk("sc1_lat", 64'(r_lat), 64'd2);
        req(AMO, 5'b00011, D, 1'b0, 64'h80, 64'h0, 64'hCD);
        chk("sc2_rdata", r_rdata, 64'd1);
        chk("sc2_wen", 64'(r_wen), 64'd0);
        chk("sc2_mem", peek8(128), 64'hAB);
        req(AMO, 5'b00010, D, 1'b0, 64'h80, 64'h0, 64'h0);
        req(ST, 5'd0, W, 1'b0, 64'h84, 64'h0, 64'h55);
        req(AMO, 5'b00011, D, 1'b0, 64'h80, 64'h0, 64'hCC);
        chk("sc3_rdata", r_rdata, 64'd1);
        chk("sc3_mem", peek8(128), 64'h0000_0055_0000_00AB);

        req(ST, 5'd0, D, 1'b0, 64'h60, 64'h0, 64'h1111);
        w0 = wen_cnt;
        d0 = done_cnt;
        op = AMO; f5 = 5'b00001; size = D; uns = 1'b0;
        base = 64'h60; offset = 64'h0; wdata = 64'h2222;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_wen", 64'(m_wen), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_ready", 64'(ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_wcnt", 64'(wen_cnt - w0), 64'd0);
        chk("rstmid_done", 64'(done_cnt - d0), 64'd0);
        chk("rstmid_mem", peek8(96), 64'h1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/riscv_core_lsu_amo.md
Name: riscv_core_lsu_amo

Overview:
- Load/store/atomic initiator that drives the core data memory port: byte-addressed, synchronous write, combinational read with size select and load extension.
- Accepts one request at a time from the execute stage and converts it into memory cycles.
- Performs read-modify-write for RV64A AMOs and keeps the LR/SC reservation.
- Sits between the execute stage and the data memory.

Parameters:
XLEN, 64, data/address width
MLEN, 256, memory size in bytes; used for range check

Ports:
i_data_mem_clk  in  1  clock
i_data_mem_rst_n  in  1  reset
i_lsu_valid  in  1  request valid
o_lsu_ready  out  1  LSU can accept; equals (state==IDLE)
i_lsu_op  in  2  00 load, 01 store, 10 atomic, 11 reserved
i_lsu_funct5  in  5  AMO function (atomic only)
i_lsu_size  in  2  00 B, 01 H, 10 W, 11 D
i_lsu_unsigned  in  1  loads: 1 = zero-extend
i_lsu_base  in  XLEN  rs1 value
i_lsu_offset  in  XLEN  sign-extended immediate
i_lsu_wdata  in  XLEN  rs2 value
o_lsu_done  out  1  one-cycle completion pulse
o_lsu_rdata  out  XLEN  load / AMO-old / SC status result
o_lsu_fault  out  1  valid with done: misaligned, out-of-range or illegal
o_mem_w_en  out  1  memory write enable
o_mem_ld_extend  out  1  memory sign-extend select
o_mem_r_w_size  out  2  memory access size
o_mem_address  out  XLEN  memory byte address
o_mem_wdata  out  XLEN  memory write data
i_mem_rdata  in  XLEN  memory read data (combinational)

Behaviour:
- Reset is asynchronous, active-low on i_data_mem_rst_n; clock is i_data_mem_clk.
- Reset values:
  - state IDLE, so o_lsu_ready=1.
  - o_lsu_done, o_lsu_fault, o_lsu_rdata = 0.
  - o_mem_w_en = 0; all other memory outputs = 0.
  - Reservation cleared.
- Handshake: request accepted on a rising edge with i_lsu_valid & o_lsu_ready. All request fields are registered at acceptance; inputs are ignored otherwise.
- Address: addr = base + offset, modulo 2^XLEN.
- Fault check at acceptance; any of these sets the fault:
  - addr not aligned to the size.
  - addr + bytes > MLEN.
  - op==11.
  - atomic with size B/H.
  - undefined funct5.
- Faulting request goes IDLE -> RESP with no memory write; done=1, fault=1, rdata=0.
- States: IDLE, ACCESS, AMO_RD, AMO_WR, RESP.
- Memory outputs are driven from registered fields in ACCESS, AMO_RD and AMO_WR. o_mem_w_en is 0 in IDLE and RESP.
- Load: IDLE -> ACCESS -> RESP.
  - In ACCESS: w_en=0, ld_extend = ~unsigned; i_mem_rdata captured into o_lsu_rdata.
  - done pulses in RESP (acceptance edge + 2 cycles).
- Store: IDLE -> ACCESS (w_en=1, wdata=rs2) -> RESP, rdata=0.
- AMO (funct5 00000 ADD, 00001 SWAP, 00100 XOR, 01000 OR, 01100 AND, 10000 MIN, 10100 MAX, 11000 MINU, 11100 MAXU):
  - IDLE -> AMO_RD: read with ld_extend=1; old value captured.
  - AMO_RD -> AMO_WR: w_en=1, wdata = f(old, rs2).
  - AMO_WR -> RESP: rdata = old value.
  - W size: operands are the low 32 bits; MIN/MAX compare 32-bit signed, MINU/MAXU 32-bit unsigned; ADD wraps at 32 bits. Returned old value is sign-extended to 64 bits.
- LR (00010): handled like a load with ld_extend=1. Sets reservation valid and latches the reservation address addr[XLEN-1:3].
- SC (00011):
  - Success = reservation valid and addr[XLEN-1:3] matches. Success goes ACCESS with w_en=1, rdata=0.
  - Failure goes ACCESS with w_en=0, rdata=1.
  - SC always clears the reservation.
- Any store or AMO write whose addr[XLEN-1:3] equals the reservation address clears the reservation.
- A new request may be accepted on the cycle after RESP (RESP -> IDLE). Back-to-back throughput is one access per 3 cycles (load/store) and 4 cycles (AMO).
- Reset mid-operation: the state machine aborts immediately. No further memory write occurs. No done pulse is produced for the aborted request.

Test Plan:
- Store D 0x8000_0000_0000_00FF at 0x10, then load B signed from 0x10 -> rdata 0xFFFF_FFFF_FFFF_FFFF; load BU -> 0xFF; done exactly 2 cycles after accept.
- Load W at addr 0x12 -> fault=1, rdata=0, no w_en pulse. Store D at 0xF8+8=0x100 with MLEN=256 -> fault=1.
- Mem W at 0x20 = 0x7FFF_FFFF, AMOADD.W rs2=1 -> rdata 0x0000_0000_7FFF_FFFF, mem W = 0x8000_0000; a following LW -> 0xFFFF_FFFF_8000_0000.
- Mem D at 0x40 = 0xFFFF_FFFF_FFFF_FFFE (-2), AMOMAX.D rs2=5 -> mem = 5, rdata = -2. Repeat with AMOMAXU.D -> mem unchanged, rdata = 0xFFFF_FFFF_FFFF_FFFE.
- LR.D 0x80 then SC.D 0x80 rs2=0xAB -> rdata 0, mem = 0xAB. Second SC.D -> rdata 1, no write. LR, then store to 0x84, then SC -> rdata 1.
- Assert reset during AMO_RD of AMOSWAP -> w_en never asserts, memory value unchanged, ready=1 after release, no done pulse.
